// File: rtl/id_stage_if.sv
// Fetch <-> decode link: instruction/PC from fetch, redirect and stall back to it.
interface id_stage_if;
    logic [31:0] Instruction;
    logic [31:0] ProgramCounter;
    logic [31:0] BranchAddress;
    logic        BranchSelection;
    logic        IF_StallReq;

    modport master (
        output Instruction,
        output ProgramCounter,
        input  BranchAddress,
        input  BranchSelection,
        input  IF_StallReq
    );

    modport slave (
        input  Instruction,
        input  ProgramCounter,
        output BranchAddress,
        output BranchSelection,
        output IF_StallReq
    );
endinterface

// File: rtl/id_stage.sv
// Decode stage: register file, main decoder, load-use/branch hazard detection,
// in-stage branch/jump resolution and the ID/EX pipeline register.
module id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        ClockInput,
    input  logic        ResetInput,
    id_stage_if.slave   fetch,
    input  logic        WB_RegWrite,
    input  logic [4:0]  WB_WriteReg,
    input  logic [31:0] WB_WriteData,
    input  logic        MEM_RegWrite,
    input  logic [4:0]  MEM_WriteReg,
    output logic        EX_RegWrite,
    output logic        EX_MemRead,
    output logic        EX_MemWrite,
    output logic        EX_MemToReg,
    output logic        EX_ALUSrc,
    output logic [3:0]  EX_ALUOp,
    output logic [31:0] EX_RsData,
    output logic [31:0] EX_RtData,
    output logic [31:0] EX_Immediate,
    output logic [4:0]  EX_Rs,
    output logic [4:0]  EX_Rt,
    output logic [4:0]  EX_WriteReg,
    output logic [4:0]  EX_Shamt,
    output logic [31:0] EX_ProgramCounter,
    output logic        IllegalOp
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
        ALU_OR  = 4'd3, ALU_SLT = 4'd4, ALU_SLL = 4'd5
    } alu_op_t;

    typedef enum logic {ST_RUN, ST_SQUASH} squash_state_t;

    logic [31:0]   regs [32];
    logic [5:0]    opcode, funct;
    logic [4:0]    rs, rt, rd, shamt;
    logic [15:0]   imm;
    logic [31:0]   rs_data, rt_data;
    logic          dec_reg_write, dec_mem_read, dec_mem_write, dec_mem_to_reg, dec_alu_src;
    alu_op_t       dec_alu_op;
    logic [4:0]    dec_dest;
    logic          dec_zero_ext, dec_illegal, is_beq, is_bne, is_jump, rt_is_source;
    logic          rs_pending, rt_pending, load_use, branch_hazard, branch_cond;
    logic          stall, taken, squash, issue;
    logic [31:0]   pc_plus4, branch_target, jump_target;
    squash_state_t state_q, state_d;

    assign opcode = fetch.Instruction[31:26];
    assign rs     = fetch.Instruction[25:21];
    assign rt     = fetch.Instruction[20:16];
    assign rd     = fetch.Instruction[15:11];
    assign shamt  = fetch.Instruction[10:6];
    assign funct  = fetch.Instruction[5:0];
    assign imm    = fetch.Instruction[15:0];

    always_ff @(posedge ClockInput) begin
        if (ResetInput) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (WB_RegWrite && WB_WriteReg != 5'd0) begin
            regs[WB_WriteReg] <= WB_WriteData;
        end
    end

    // Writeback data is forwarded so a same-cycle write is visible to decode.
    always_comb begin
        rs_data = regs[rs];
        rt_data = regs[rt];
        if (rs == 5'd0) rs_data = '0;
        else if (WB_RegWrite && WB_WriteReg == rs) rs_data = WB_WriteData;
        if (rt == 5'd0) rt_data = '0;
        else if (WB_RegWrite && WB_WriteReg == rt) rt_data = WB_WriteData;
    end

    always_comb begin
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_alu_src    = 1'b0;
        dec_alu_op     = ALU_ADD;
        dec_dest       = 5'd0;
        dec_zero_ext   = 1'b0;
        dec_illegal    = 1'b0;
        is_beq         = 1'b0;
        is_bne         = 1'b0;
        is_jump        = 1'b0;
        rt_is_source   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                rt_is_source = 1'b1;
                dec_dest     = rd;
                if (fetch.Instruction != 32'h0) begin
                    dec_reg_write = 1'b1;
                    case (funct)
                        6'h20:   dec_alu_op = ALU_ADD;
                        6'h22:   dec_alu_op = ALU_SUB;
                        6'h24:   dec_alu_op = ALU_AND;
                        6'h25:   dec_alu_op = ALU_OR;
                        6'h2A:   dec_alu_op = ALU_SLT;
                        6'h00:   dec_alu_op = ALU_SLL;
                        default: dec_illegal = 1'b1;
                    endcase
                end
            end
            OP_ADDI: begin
                dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_dest = rt;
            end
            OP_ANDI: begin
                dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_dest = rt;
                dec_zero_ext  = 1'b1; dec_alu_op  = ALU_AND;
            end
            OP_ORI: begin
                dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_dest = rt;
                dec_zero_ext  = 1'b1; dec_alu_op  = ALU_OR;
            end
            OP_LW: begin
                dec_reg_write  = 1'b1; dec_alu_src = 1'b1; dec_dest = rt;
                dec_mem_read   = 1'b1; dec_mem_to_reg = 1'b1;
            end
            OP_SW: begin
                dec_mem_write = 1'b1; dec_alu_src = 1'b1; rt_is_source = 1'b1;
            end
            OP_BEQ: begin
                is_beq = 1'b1; rt_is_source = 1'b1;
            end
            OP_BNE: begin
                is_bne = 1'b1; rt_is_source = 1'b1;
            end
            OP_J:    is_jump = 1'b1;
            default: dec_illegal = 1'b1;
        endcase
    end

    assign rs_pending = (rs != 5'd0) && ((EX_RegWrite && EX_WriteReg == rs) ||
                                         (MEM_RegWrite && MEM_WriteReg == rs));
    assign rt_pending = (rt != 5'd0) && ((EX_RegWrite && EX_WriteReg == rt) ||
                                         (MEM_RegWrite && MEM_WriteReg == rt));
    assign load_use = EX_MemRead && (EX_WriteReg != 5'd0) &&
                      ((EX_WriteReg == rs) || (rt_is_source && EX_WriteReg == rt));
    assign branch_hazard = (is_beq || is_bne) && (rs_pending || rt_pending);
    assign branch_cond = (is_beq && rs_data == rt_data) ||
                         (is_bne && rs_data != rt_data) || is_jump;

    assign pc_plus4      = fetch.ProgramCounter + 32'd4;
    assign branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    assign jump_target   = {pc_plus4[31:28], fetch.Instruction[25:0], 2'b00};

    always_ff @(posedge ClockInput) begin
        if (ResetInput) state_q <= ST_RUN;
        else            state_q <= state_d;
    end

    // After a taken redirect the wrong-path instruction is dropped without evaluation.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        taken   = 1'b0;
        squash  = (state_q == ST_SQUASH);
        if (!ResetInput) begin
            case (state_q)
                ST_RUN: begin
                    stall = load_use || branch_hazard;
                    taken = !stall && branch_cond;
                    if (taken) state_d = ST_SQUASH;
                end
                ST_SQUASH: state_d = ST_RUN;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    assign fetch.IF_StallReq     = stall;
    assign fetch.BranchSelection = taken;
    assign fetch.BranchAddress   = is_jump ? jump_target : branch_target;
    assign issue = !stall && !squash && !dec_illegal;

    always_ff @(posedge ClockInput) begin
        if (ResetInput) begin
            EX_RegWrite <= 1'b0; EX_MemRead <= 1'b0; EX_MemWrite <= 1'b0;
            EX_MemToReg <= 1'b0; EX_ALUSrc  <= 1'b0; EX_ALUOp    <= 4'd0;
            EX_RsData   <= '0;   EX_RtData  <= '0;   EX_Immediate <= '0;
            EX_Rs <= '0; EX_Rt <= '0; EX_WriteReg <= '0; EX_Shamt <= '0;
            EX_ProgramCounter <= RESET_PC;
            IllegalOp <= 1'b0;
        end else begin
            EX_ProgramCounter <= fetch.ProgramCounter;
            IllegalOp <= dec_illegal && !stall && !squash;
            if (issue) begin
                EX_RegWrite  <= dec_reg_write;
                EX_MemRead   <= dec_mem_read;
                EX_MemWrite  <= dec_mem_write;
                EX_MemToReg  <= dec_mem_to_reg;
                EX_ALUSrc    <= dec_alu_src;
                EX_ALUOp     <= dec_alu_op;
                EX_RsData    <= rs_data;
                EX_RtData    <= rt_data;
                EX_Immediate <= dec_zero_ext ? {16'h0, imm} : {{16{imm[15]}}, imm};
                EX_Rs <= rs; EX_Rt <= rt; EX_WriteReg <= dec_dest; EX_Shamt <= shamt;
            end else begin
                EX_RegWrite <= 1'b0; EX_MemRead <= 1'b0; EX_MemWrite <= 1'b0;
                EX_MemToReg <= 1'b0; EX_ALUSrc  <= 1'b0; EX_ALUOp    <= 4'd0;
                EX_RsData   <= '0;   EX_RtData  <= '0;   EX_Immediate <= '0;
                EX_Rs <= '0; EX_Rt <= '0; EX_WriteReg <= '0; EX_Shamt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Randomized bench for id_stage against an instruction-level reference model,
// plus directed scenarios for bypass, load-use, branches, jumps and illegal ops.
module tb_id_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we, mem_we;
    logic [4:0]  wb_reg, mem_reg;
    logic [31:0] wb_data;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, illegal_op;
    logic [3:0]  ex_aluop;
    logic [31:0] ex_rsdata, ex_rtdata, ex_imm, ex_pc;
    logic [4:0]  ex_rs, ex_rt, ex_writereg, ex_shamt;

    always #5 clk = ~clk;

    id_stage_if fetch_bus();

    id_stage #(.RESET_PC(RESET_PC)) dut (
        .ClockInput(clk), .ResetInput(rst), .fetch(fetch_bus),
        .WB_RegWrite(wb_we), .WB_WriteReg(wb_reg), .WB_WriteData(wb_data),
        .MEM_RegWrite(mem_we), .MEM_WriteReg(mem_reg),
        .EX_RegWrite(ex_regwrite), .EX_MemRead(ex_memread), .EX_MemWrite(ex_memwrite),
        .EX_MemToReg(ex_memtoreg), .EX_ALUSrc(ex_alusrc), .EX_ALUOp(ex_aluop),
        .EX_RsData(ex_rsdata), .EX_RtData(ex_rtdata), .EX_Immediate(ex_imm),
        .EX_Rs(ex_rs), .EX_Rt(ex_rt), .EX_WriteReg(ex_writereg), .EX_Shamt(ex_shamt),
        .EX_ProgramCounter(ex_pc), .IllegalOp(illegal_op)
    );

    typedef enum {I_NOP, I_ADD, I_SUB, I_AND, I_OR, I_SLT, I_SLL, I_ADDI, I_ANDI,
                  I_ORI, I_LW, I_SW, I_BEQ, I_BNE, I_J, I_BAD} mnem_t;

    int num_compared = 0;
    int num_mismatched = 0;

    logic [31:0] m_regs [32];
    logic        m_squash, m_ex_memread, m_ex_regwrite;
    logic [4:0]  m_ex_writereg;
    logic        last_stall, last_taken;
    logic [31:0] last_target;
    logic        obs_stall, obs_bsel;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] f);
        return {6'h00, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    function automatic mnem_t classify(input logic [31:0] ins);
        mnem_t m;
        m = I_BAD;
        if (ins == 32'h0) m = I_NOP;
        else case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: m = I_ADD;  6'h22: m = I_SUB; 6'h24: m = I_AND;
                6'h25: m = I_OR;   6'h2A: m = I_SLT; 6'h00: m = I_SLL;
                default: m = I_BAD;
            endcase
            6'h08: m = I_ADDI; 6'h0C: m = I_ANDI; 6'h0D: m = I_ORI;
            6'h23: m = I_LW;   6'h2B: m = I_SW;
            6'h04: m = I_BEQ;  6'h05: m = I_BNE;  6'h02: m = I_J;
            default: m = I_BAD;
        endcase
        return m;
    endfunction

    function automatic logic writesReg(input mnem_t m);
        return m inside {I_ADD, I_SUB, I_AND, I_OR, I_SLT, I_SLL, I_ADDI, I_ANDI, I_ORI, I_LW};
    endfunction

    function automatic logic usesImm(input mnem_t m);
        return m inside {I_ADDI, I_ANDI, I_ORI, I_LW, I_SW};
    endfunction

    function automatic logic [3:0] aluCode(input mnem_t m);
        case (m)
            I_SUB:         return 4'd1;
            I_AND, I_ANDI: return 4'd2;
            I_OR,  I_ORI:  return 4'd3;
            I_SLT:         return 4'd4;
            I_SLL:         return 4'd5;
            default:       return 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] readReg(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (wb_we && wb_reg == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic logic pending(input logic [4:0] r);
        return (r != 5'd0) && ((m_ex_regwrite && m_ex_writereg == r) || (mem_we && mem_reg == r));
    endfunction

    task automatic applyReset();
        rst = 1'b1;
        fetch_bus.Instruction    = $urandom;
        fetch_bus.ProgramCounter = $urandom;
        wb_we = 1'b1; wb_reg = 5'($urandom_range(1, 31)); wb_data = $urandom;
        mem_we = 1'b1; mem_reg = 5'($urandom_range(1, 31));
        repeat (2) begin
            @(negedge clk);
            checkOutput("reset_bsel", fetch_bus.BranchSelection, 0);
            checkOutput("reset_stall", fetch_bus.IF_StallReq, 0);
            @(posedge clk); #1;
        end
        checkOutput("reset_regwrite", ex_regwrite, 0);
        checkOutput("reset_memread", ex_memread, 0);
        checkOutput("reset_memwrite", ex_memwrite, 0);
        checkOutput("reset_memtoreg", ex_memtoreg, 0);
        checkOutput("reset_alusrc", ex_alusrc, 0);
        checkOutput("reset_aluop", ex_aluop, 0);
        checkOutput("reset_rsdata", ex_rsdata, 0);
        checkOutput("reset_rtdata", ex_rtdata, 0);
        checkOutput("reset_imm", ex_imm, 0);
        checkOutput("reset_regs", {ex_rs, ex_rt, ex_writereg, ex_shamt}, 0);
        checkOutput("reset_pc", ex_pc, RESET_PC);
        checkOutput("reset_illegal", illegal_op, 0);
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_squash = 0; m_ex_memread = 0; m_ex_regwrite = 0; m_ex_writereg = 0;
        rst = 1'b0;
    endtask

    // One decode cycle: drive, predict from the instruction-level model, check both sides of the edge.
    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic w_we, input logic [4:0] w_reg, input logic [31:0] w_data,
                                 input logic m_we, input logic [4:0] m_reg);
        mnem_t       mn;
        logic [4:0]  s, t;
        logic [31:0] s_val, t_val, sext, target;
        logic        reads_rt, exp_stall, exp_taken, exp_issue;
        fetch_bus.Instruction = ins; fetch_bus.ProgramCounter = pc;
        wb_we = w_we; wb_reg = w_reg; wb_data = w_data; mem_we = m_we; mem_reg = m_reg;
        mn = classify(ins);
        s = ins[25:21]; t = ins[20:16];
        s_val = readReg(s); t_val = readReg(t);
        sext = {{16{ins[15]}}, ins[15:0]};
        reads_rt = (ins[31:26] == 6'h00) || mn inside {I_SW, I_BEQ, I_BNE};
        exp_stall = 0; exp_taken = 0; target = 32'h0;
        if (!m_squash) begin
            exp_stall = (m_ex_memread && m_ex_writereg != 0 &&
                         (m_ex_writereg == s || (reads_rt && m_ex_writereg == t))) ||
                        ((mn == I_BEQ || mn == I_BNE) && (pending(s) || pending(t)));
            if (!exp_stall) begin
                if (mn == I_BEQ) exp_taken = (s_val == t_val);
                if (mn == I_BNE) exp_taken = (s_val != t_val);
                if (mn == I_J)   exp_taken = 1;
                if (mn == I_J) target = ((pc + 32'd4) & 32'hF000_0000) | ({6'b0, ins[25:0]} << 2);
                else           target = pc + 32'd4 + (sext << 2);
            end
        end
        exp_issue = !m_squash && !exp_stall && mn != I_BAD;

        @(negedge clk);
        obs_stall = fetch_bus.IF_StallReq;
        obs_bsel  = fetch_bus.BranchSelection;
        checkOutput("if_stallreq", obs_stall, exp_stall);
        checkOutput("branch_sel", obs_bsel, exp_taken);
        if (exp_taken) checkOutput("branch_addr", fetch_bus.BranchAddress, target);

        @(posedge clk); #1;
        checkOutput("ex_regwrite", ex_regwrite, exp_issue && writesReg(mn));
        checkOutput("ex_memread", ex_memread, exp_issue && mn == I_LW);
        checkOutput("ex_memwrite", ex_memwrite, exp_issue && mn == I_SW);
        checkOutput("ex_memtoreg", ex_memtoreg, exp_issue && mn == I_LW);
        checkOutput("ex_alusrc", ex_alusrc, exp_issue && usesImm(mn));
        checkOutput("ex_aluop", ex_aluop, exp_issue ? aluCode(mn) : 4'd0);
        checkOutput("illegal_op", illegal_op, !m_squash && !exp_stall && mn == I_BAD);
        checkOutput("ex_pc", ex_pc, pc);
        if (exp_issue) begin
            checkOutput("ex_rs", ex_rs, s);
            checkOutput("ex_rt", ex_rt, t);
            checkOutput("ex_shamt", ex_shamt, ins[10:6]);
            checkOutput("ex_rsdata", ex_rsdata, s_val);
            checkOutput("ex_rtdata", ex_rtdata, t_val);
            if (writesReg(mn))
                checkOutput("ex_writereg", ex_writereg, (ins[31:26] == 6'h00) ? ins[15:11] : t);
            if (usesImm(mn))
                checkOutput("ex_imm", ex_imm, (mn == I_ANDI || mn == I_ORI) ? {16'h0, ins[15:0]} : sext);
        end

        m_ex_memread  = exp_issue && mn == I_LW;
        m_ex_regwrite = exp_issue && writesReg(mn);
        m_ex_writereg = (ins[31:26] == 6'h00) ? ins[15:11] : t;
        m_squash      = exp_taken;
        if (w_we && w_reg != 5'd0) m_regs[w_reg] = w_data;
        last_stall = exp_stall; last_taken = exp_taken; last_target = target;
    endtask

    function automatic logic [31:0] randomInstr();
        logic [4:0]  a, b, d;
        logic [15:0] im;
        a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
        im = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15)) : 16'($urandom);
        case ($urandom_range(0, 17))
            0:  return rtype(a, b, d, 6'h20);
            1:  return rtype(a, b, d, 6'h22);
            2:  return rtype(a, b, d, 6'h24);
            3:  return rtype(a, b, d, 6'h25);
            4:  return rtype(a, b, d, 6'h2A);
            5:  return {6'h00, 5'd0, b, d, 5'($urandom_range(0, 31)), 6'h00};
            6:  return itype(6'h08, a, b, im);
            7:  return itype(6'h0C, a, b, im);
            8:  return itype(6'h0D, a, b, im);
            9, 10: return itype(6'h23, a, b, im);
            11: return itype(6'h2B, a, b, im);
            12: return itype(6'h04, a, b, im);
            13: return itype(6'h05, a, b, im);
            14: return {6'h02, 26'($urandom)};
            15: return 32'h0;
            16: return rtype(a, b, d, 6'h21);
            default: return itype(6'h3F, a, b, im);
        endcase
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] cur_ins, cur_pc;
        applyReset();

        for (int r = 1; r < 32; r++) begin
            applyStimulus(rtype(5'(r), 5'(r), 5'd0, 6'h25), 32'(r * 4), 0, 0, 0, 0, 0);
            checkOutput("reset_reg_read", ex_rsdata, 0);
        end

        applyStimulus(rtype(5'd5, 5'd0, 5'd3, 6'h20), 32'h0, 1, 5'd5, 32'h1234, 0, 0);
        checkOutput("bypass_rsdata", ex_rsdata, 32'h1234);
        checkOutput("bypass_writereg", ex_writereg, 3);
        checkOutput("bypass_aluop", ex_aluop, 0);
        checkOutput("bypass_regwrite", ex_regwrite, 1);
        applyStimulus(rtype(5'd0, 5'd5, 5'd1, 6'h20), 32'h4, 1, 5'd0, 32'hDEAD_BEEF, 0, 0);
        checkOutput("r0_reads_zero", ex_rsdata, 0);

        applyStimulus(itype(6'h23, 5'd1, 5'd2, 16'd4), 32'h8, 0, 0, 0, 0, 0);
        applyStimulus(rtype(5'd2, 5'd3, 5'd4, 6'h20), 32'hC, 0, 0, 0, 0, 0);
        checkOutput("loaduse_stall", obs_stall, 1);
        checkOutput("loaduse_bubble", ex_regwrite, 0);
        applyStimulus(rtype(5'd2, 5'd3, 5'd4, 6'h20), 32'hC, 0, 0, 0, 0, 0);
        checkOutput("loaduse_issue", ex_regwrite, 1);
        applyStimulus(itype(6'h23, 5'd1, 5'd2, 16'd4), 32'h10, 0, 0, 0, 0, 0);
        applyStimulus(rtype(5'd6, 5'd3, 5'd4, 6'h20), 32'h14, 0, 0, 0, 0, 0);
        checkOutput("loaduse_nostall", obs_stall, 0);

        applyStimulus(32'h0, 32'h18, 1, 5'd1, 32'd7, 0, 0);
        applyStimulus(32'h0, 32'h1C, 1, 5'd2, 32'd7, 0, 0);
        applyStimulus(itype(6'h04, 5'd1, 5'd2, 16'h0003), 32'h40, 0, 0, 0, 0, 0);
        checkOutput("beq_taken", obs_bsel, 1);
        applyStimulus(rtype(5'd1, 5'd2, 5'd7, 6'h20), 32'h50, 0, 0, 0, 0, 0);
        checkOutput("squash_regwrite", ex_regwrite, 0);
        applyStimulus(32'h0, 32'h54, 1, 5'd2, 32'd8, 0, 0);
        applyStimulus(itype(6'h04, 5'd1, 5'd2, 16'h0003), 32'h40, 0, 0, 0, 0, 0);
        checkOutput("beq_not_taken", obs_bsel, 0);

        applyStimulus(itype(6'h05, 5'd1, 5'd2, 16'hFFFE), 32'h100, 0, 0, 0, 0, 0);
        checkOutput("bne_back_taken", obs_bsel, 1);
        applyStimulus(32'h0, 32'hFC, 0, 0, 0, 0, 0);
        applyStimulus({6'h02, 26'h40}, 32'h8000_0000, 0, 0, 0, 0, 0);
        checkOutput("jump_taken", obs_bsel, 1);
        applyStimulus(32'h0, 32'h8000_0100, 0, 0, 0, 0, 0);

        applyStimulus(itype(6'h04, 5'd1, 5'd2, 16'h0), 32'h200, 0, 0, 0, 1, 5'd1);
        checkOutput("branch_haz_stall", obs_stall, 1);
        checkOutput("branch_haz_nosel", obs_bsel, 0);
        applyStimulus(itype(6'h04, 5'd1, 5'd2, 16'h0), 32'h200, 0, 0, 0, 0, 0);
        applyStimulus(itype(6'h3F, 5'd0, 5'd0, 16'h0), 32'h204, 0, 0, 0, 0, 0);
        checkOutput("illegal_set", illegal_op, 1);
        checkOutput("illegal_bubble", ex_regwrite, 0);
        applyStimulus(32'h0, 32'h208, 0, 0, 0, 0, 0);
        checkOutput("illegal_clear", illegal_op, 0);

        // Random phase: fetch holds on stall and follows redirects like the real fetch stage.
        cur_pc = 32'h1000;
        cur_ins = randomInstr();
        for (int n = 0; n < 600; n++) begin
            if (n % 200 == 199) begin
                applyReset();
                cur_pc = 32'h1000;
                cur_ins = randomInstr();
            end
            applyStimulus(cur_ins, cur_pc, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          $urandom, ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
            if (!last_stall) begin
                cur_pc = last_taken ? last_target : cur_pc + 32'd4;
                cur_ins = randomInstr();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage directly downstream of the fetch stage; consumes Instruction/ProgramCounter every cycle.
- Contains the 32x32 register file, main decoder, load-use and branch hazard detection, in-stage branch/jump resolution, and the ID/EX pipeline register.
- Drives BranchAddress, BranchSelection and IF_StallReq back to fetch.

Parameters:
- RESET_PC, 32'h0000_0000: value loaded into EX_ProgramCounter on reset.

Ports:
ClockInput  in  1  single clock; all state updates on rising edge
ResetInput  in  1  synchronous, active-high reset
Instruction  in  32  fetched instruction, valid in the cycle presented
ProgramCounter  in  32  byte address of Instruction
WB_RegWrite  in  1  writeback enable
WB_WriteReg  in  5  writeback destination
WB_WriteData  in  32  writeback data
MEM_RegWrite  in  1  MEM-stage instruction writes a register
MEM_WriteReg  in  5  MEM-stage destination
BranchAddress  out  32  redirect target to fetch
BranchSelection  out  1  redirect taken this cycle
IF_StallReq  out  1  hold fetch (PC and Instruction unchanged next cycle)
EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc  out  1 each  registered controls
EX_ALUOp  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL
EX_RsData, EX_RtData  out  32  registered operand values
EX_Immediate  out  32  extended immediate
EX_Rs, EX_Rt, EX_WriteReg  out  5  register numbers
EX_Shamt  out  5  shift amount
EX_ProgramCounter  out  32  PC of the instruction in EX
IllegalOp  out  1  registered; unsupported opcode or funct decoded

Behaviour:
- Reset (synchronous, ResetInput=1 at the edge):
  - all 32 registers and all EX_* outputs cleared to 0; EX_ProgramCounter=RESET_PC; squash flag=0; IllegalOp=0.
  - BranchSelection and IF_StallReq are 0 while ResetInput=1.
  - Reset overrides a stall or branch in progress.
- Register file:
  - two combinational reads (rs=Instruction[25:21], rt=[20:16]); one write at the edge when WB_RegWrite=1 and WB_WriteReg!=0.
  - r0 always reads 0.
  - Write-through: a read of WB_WriteReg while WB_RegWrite=1 (and WB_WriteReg!=0) returns WB_WriteData in the same cycle.
- Decode subset:
  - R-type op 0x00: funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x00 sll. Dest=rd; ALUSrc=0.
  - I-type dest=rt, ALUSrc=1:
    - addi 0x08: sign-extended immediate, ADD.
    - andi 0x0C / ori 0x0D: zero-extended immediate.
    - lw 0x23: MemRead=1, MemToReg=1, ADD.
  - sw 0x2B: MemWrite=1, RegWrite=0, ADD.
  - beq 0x04, bne 0x05, j 0x02: no EX side effects; all EX controls 0.
  - Any other encoding: bubble (all EX controls 0) and IllegalOp=1 for one cycle.
  - Instruction 0x00000000 is a nop: RegWrite=0.
- Latency: an instruction presented in cycle N appears on EX_* after edge N.
- Load-use stall (combinational):
  - Condition: EX_MemRead=1, EX_WriteReg!=0, and EX_WriteReg equals rs, or equals rt when rt is a source (R-type, sw, beq, bne).
  - Effect: IF_StallReq=1; a bubble (controls 0) is loaded into ID/EX.
- Branch operand stall:
  - Condition: beq/bne whose rs or rt (nonzero) matches EX_WriteReg with EX_RegWrite=1, or MEM_WriteReg with MEM_RegWrite=1.
  - Effect: IF_StallReq=1; bubble loaded.
- Branch/jump resolution (only when not stalled):
  - beq: equal operands -> taken. bne: unequal operands -> taken.
  - Branch target = ProgramCounter+4+(signext(imm)<<2).
  - j: always taken; target = {ProgramCounter+4[31:28], Instruction[25:0], 2'b00}.
  - BranchSelection=1 for exactly that cycle.
  - Stall has priority over branch: BranchSelection=0 whenever IF_StallReq=1.
- Squash (no delay slot): a taken branch or jump sets the squash flag. The next presented instruction is loaded as a bubble, with no branch or stall evaluation, and the flag is then cleared.
- Address arithmetic is 32-bit modulo 2^32; wrap-around is silently ignored.

Test Plan:
- Reset: ResetInput=1 for 2 cycles with random Instruction -> all EX_* = 0, BranchSelection=0, IF_StallReq=0; r1..r31 read 0.
- Writeback and bypass: WB write r5=0x1234 while `add r3,r5,r0` is decoded -> EX_RsData=0x1234, EX_WriteReg=3, EX_ALUOp=0, EX_RegWrite=1. Write to r0 -> r0 still reads 0.
- Load-use: `lw r2,4(r1)` then `add r4,r2,r3` -> IF_StallReq=1 for one cycle with a bubble in EX; the add issues the following cycle. With `add r4,r6,r3` instead -> no stall.
- beq taken: r1=r2=7, PC=0x40, imm=0x0003 -> BranchSelection=1, BranchAddress=0x50; next instruction squashed (EX_RegWrite=0). With r2=8 -> BranchSelection=0.
- bne backward and jump: PC=0x100, imm=0xFFFE, unequal operands -> BranchAddress=0xFC. `j 0x0000040` at PC=0x8000_0000 -> BranchAddress=0x8000_0100.
- Branch hazard and illegal op: beq r1 with MEM_RegWrite=1, MEM_WriteReg=1 -> IF_StallReq=1, BranchSelection=0 that cycle. Opcode 0x3F -> bubble and IllegalOp=1 for one cycle.
